// File: rtl/updi_response_collector_if.sv
// -----------------------------------------------------------------------------
// updi_response_collector_if
//
// Connection between the UPDI response collector and the external UART RX
// FIFO. The FIFO is first-word fall-through: fifo_data is valid whenever
// fifo_empty is low, and asserting fifo_rd_en in that cycle consumes the byte
// at the next rising clock edge.
//
// Signals
//   fifo_data   RX FIFO head byte (driven by the FIFO)
//   fifo_empty  RX FIFO empty flag (driven by the FIFO)
//   fifo_rd_en  pop request, combinational (driven by the collector)
//
// Modports
//   master  collector side: samples data/empty, drives the pop
//   slave   FIFO side: drives data/empty, samples the pop
// -----------------------------------------------------------------------------
interface updi_response_collector_if;
  logic [7:0] fifo_data;
  logic       fifo_empty;
  logic       fifo_rd_en;

  modport master (
    input  fifo_data,
    input  fifo_empty,
    output fifo_rd_en
  );

  modport slave (
    output fifo_data,
    output fifo_empty,
    input  fifo_rd_en
  );
endinterface : updi_response_collector_if

// File: rtl/updi_response_collector.sv
// -----------------------------------------------------------------------------
// updi_response_collector
//
// Receive side of the UPDI instruction queue. UPDI is a single-wire link, so
// every byte the transmitter sends is echoed back into the RX FIFO ahead of
// the target's reply. For each transaction this block pops and drops the echo
// bytes, then captures the response bytes into a register buffer. Response
// positions flagged in ack_mask must carry ACK_BYTE; each good ACK pulses
// ack_received, a bad one aborts the transaction with error. A line that stays
// silent for TIMEOUT_CLKS clocks also aborts with error. Every accepted start
// ends with exactly one done pulse (unless reset intervenes).
//
// Parameters
//   MAX_RESP_SIZE   response buffer capacity in bytes
//   RESP_ADDR_BITS  buffer index width
//   TIMEOUT_CLKS    idle clocks tolerated between consumed bytes
//   ACK_BYTE        value the target sends as ACK
//
// Ports
//   clk, rst        system clock, synchronous active-high reset
//   start / ready   transaction request, accepted only while ready=1
//   done            1-cycle pulse at end of transaction
//   error           1-cycle pulse with done on timeout or ACK mismatch
//   ack_received    1-cycle pulse per matching ACK byte
//   echo_len        echo bytes to discard (latched on start)
//   resp_len        response bytes to capture (latched, clamped on start)
//   ack_mask        bit i: response byte i must be ACK_BYTE (latched)
//   resp_data       captured bytes, registered, held until overwritten
//   resp_count      bytes captured in the current/last transaction
//   fifo            RX FIFO connection (master side)
// -----------------------------------------------------------------------------
module updi_response_collector #(
  parameter int         MAX_RESP_SIZE  = 16,
  parameter int         RESP_ADDR_BITS = $clog2(MAX_RESP_SIZE),
  parameter int         TIMEOUT_CLKS   = 100000,
  parameter logic [7:0] ACK_BYTE       = 8'h40
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic                              start,
  output logic                              ready,
  output logic                              done,
  output logic                              error,
  output logic                              ack_received,
  input  logic [7:0]                        echo_len,
  input  logic [RESP_ADDR_BITS:0]           resp_len,
  input  logic [MAX_RESP_SIZE-1:0]          ack_mask,
  output logic [MAX_RESP_SIZE-1:0][7:0]     resp_data,
  output logic [RESP_ADDR_BITS:0]           resp_count,
  updi_response_collector_if.master         fifo
);

  localparam int LEN_W = RESP_ADDR_BITS + 1;
  // The byte counter serves both phases, so it must also hold any 8-bit
  // echo_len; the capture index is taken from its low bits.
  localparam int CNT_W = (LEN_W > 8) ? LEN_W : 8;
  localparam int TMR_W = $clog2(TIMEOUT_CLKS + 1);

  localparam logic [LEN_W-1:0] MAX_LEN  = LEN_W'(MAX_RESP_SIZE);
  localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(TIMEOUT_CLKS - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_DISCARD,
    S_CAPTURE
  } state_e;

  state_e                        state_q, state_d;
  logic                          ready_q, ready_d;
  logic                          done_q, done_d;
  logic                          error_q, error_d;
  logic                          ack_q, ack_d;
  logic [CNT_W-1:0]              cnt_q, cnt_d;
  logic [TMR_W-1:0]              tmr_q, tmr_d;
  logic [7:0]                    echo_len_q, echo_len_d;
  logic [LEN_W-1:0]              resp_len_q, resp_len_d;
  logic [MAX_RESP_SIZE-1:0]      ack_mask_q, ack_mask_d;
  logic [MAX_RESP_SIZE-1:0][7:0] resp_data_q, resp_data_d;
  logic [LEN_W-1:0]              resp_count_q, resp_count_d;

  logic                          busy;
  logic                          accept;
  logic                          timeout_hit;
  logic                          pop;
  logic                          echo_last;
  logic                          resp_last;
  logic                          ack_bit;
  logic                          ack_ok;
  logic [LEN_W-1:0]              resp_len_clamped;
  logic [RESP_ADDR_BITS-1:0]     idx;

  // ---------------------------------------------------------------------------
  // Datapath decodes
  // ---------------------------------------------------------------------------
  assign busy        = (state_q != S_IDLE);
  assign accept      = (state_q == S_IDLE) && ready_q && start;
  // The timeout wins over a byte that happens to arrive in the same cycle, so
  // an aborted transaction never consumes anything on its final cycle.
  assign timeout_hit = busy && (tmr_q == TMR_LAST);
  // Pops are combinational so a byte is consumed the cycle it becomes visible;
  // the rst term keeps the FIFO untouched while the collector is held in reset.
  assign pop         = busy && !fifo.fifo_empty && !timeout_hit && !rst;

  assign idx         = cnt_q[RESP_ADDR_BITS-1:0];
  assign echo_last   = (cnt_q == CNT_W'(echo_len_q) - CNT_W'(1));
  assign resp_last   = (cnt_q == CNT_W'(resp_len_q) - CNT_W'(1));
  assign ack_bit     = ack_mask_q[idx];
  assign ack_ok      = (fifo.fifo_data == ACK_BYTE);

  assign resp_len_clamped = (resp_len > MAX_LEN) ? MAX_LEN : resp_len;

  // ---------------------------------------------------------------------------
  // Next-state and output logic
  // ---------------------------------------------------------------------------
  // NOTE: every variable assigned here gets a default first so that no path
  // leaves a value unassigned, which would otherwise infer a latch.
  always_comb begin
    state_d      = state_q;
    ready_d      = (state_q == S_IDLE) && !accept;
    done_d       = 1'b0;
    error_d      = 1'b0;
    ack_d        = 1'b0;
    cnt_d        = cnt_q;
    tmr_d        = tmr_q;
    echo_len_d   = echo_len_q;
    resp_len_d   = resp_len_q;
    ack_mask_d   = ack_mask_q;
    resp_data_d  = resp_data_q;
    resp_count_d = resp_count_q;

    unique case (state_q)
      S_IDLE: begin
        if (accept) begin
          echo_len_d   = echo_len;
          resp_len_d   = resp_len_clamped;
          ack_mask_d   = ack_mask;
          cnt_d        = '0;
          tmr_d        = '0;
          resp_count_d = '0;
          if (echo_len != 8'd0) begin
            state_d = S_DISCARD;
          end else if (resp_len_clamped != '0) begin
            state_d = S_CAPTURE;
          end else begin
            // Nothing to receive: complete immediately without leaving IDLE.
            done_d = 1'b1;
          end
        end
      end

      S_DISCARD: begin
        if (timeout_hit) begin
          error_d = 1'b1;
          done_d  = 1'b1;
          state_d = S_IDLE;
        end else if (pop) begin
          tmr_d = '0;
          if (echo_last) begin
            cnt_d = '0;
            if (resp_len_q != '0) begin
              state_d = S_CAPTURE;
            end else begin
              done_d  = 1'b1;
              state_d = S_IDLE;
            end
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end else begin
          tmr_d = tmr_q + TMR_W'(1);
        end
      end

      S_CAPTURE: begin
        if (timeout_hit) begin
          error_d = 1'b1;
          done_d  = 1'b1;
          state_d = S_IDLE;
        end else if (pop) begin
          tmr_d             = '0;
          cnt_d             = cnt_q + CNT_W'(1);
          // A wrong ACK is still stored so the host can inspect what arrived.
          resp_data_d[idx]  = fifo.fifo_data;
          resp_count_d      = resp_count_q + LEN_W'(1);
          if (ack_bit && !ack_ok) begin
            error_d = 1'b1;
            done_d  = 1'b1;
            state_d = S_IDLE;
          end else begin
            ack_d = ack_bit;
            if (resp_last) begin
              done_d  = 1'b1;
              state_d = S_IDLE;
            end
          end
        end else begin
          tmr_d = tmr_q + TMR_W'(1);
        end
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // State registers
  // ---------------------------------------------------------------------------
  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // its _d value from before the edge, independent of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= S_IDLE;
      ready_q      <= 1'b0;
      done_q       <= 1'b0;
      error_q      <= 1'b0;
      ack_q        <= 1'b0;
      cnt_q        <= '0;
      tmr_q        <= '0;
      echo_len_q   <= '0;
      resp_len_q   <= '0;
      ack_mask_q   <= '0;
      // NOTE: the response buffer is reset because its contents are visible
      // at the ports; a purely internal buffer would normally skip this.
      resp_data_q  <= '0;
      resp_count_q <= '0;
    end else begin
      state_q      <= state_d;
      ready_q      <= ready_d;
      done_q       <= done_d;
      error_q      <= error_d;
      ack_q        <= ack_d;
      cnt_q        <= cnt_d;
      tmr_q        <= tmr_d;
      echo_len_q   <= echo_len_d;
      resp_len_q   <= resp_len_d;
      ack_mask_q   <= ack_mask_d;
      resp_data_q  <= resp_data_d;
      resp_count_q <= resp_count_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------------
  assign fifo.fifo_rd_en = pop;
  assign ready           = ready_q;
  assign done            = done_q;
  assign error           = error_q;
  assign ack_received    = ack_q;
  assign resp_data       = resp_data_q;
  assign resp_count      = resp_count_q;

endmodule : updi_response_collector

// File: tb/tb_updi_response_collector.sv
// -----------------------------------------------------------------------------
// tb_updi_response_collector
//
// Directed bench for updi_response_collector. A queue models the RX FIFO;
// expected capture bytes go into a scoreboard queue when the FIFO is loaded
// and are popped and compared against resp_data when done is seen.
// -----------------------------------------------------------------------------
module tb_updi_response_collector;

  localparam int MAX = 16;
  localparam int AB  = 4;
  localparam int TO  = 50;

  logic                  clk = 1'b0;
  logic                  rst;
  logic                  start;
  logic                  ready, done, error, ack_received;
  logic [7:0]            echo_len;
  logic [AB:0]           resp_len;
  logic [MAX-1:0]        ack_mask;
  logic [MAX-1:0][7:0]   resp_data;
  logic [AB:0]           resp_count;

  updi_response_collector_if bus ();

  updi_response_collector #(
    .MAX_RESP_SIZE (MAX),
    .TIMEOUT_CLKS  (TO),
    .ACK_BYTE      (8'h40)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .start        (start),
    .ready        (ready),
    .done         (done),
    .error        (error),
    .ack_received (ack_received),
    .echo_len     (echo_len),
    .resp_len     (resp_len),
    .ack_mask     (ack_mask),
    .resp_data    (resp_data),
    .resp_count   (resp_count),
    .fifo         (bus.master)
  );

  always #5 clk = ~clk;

  int         n_checks = 0;
  int         n_errors = 0;
  logic [7:0] fifo_mem[$];
  logic [7:0] exp_q[$];
  bit         toggle_en = 0;
  bit         gate = 0;
  bit         popped;
  int         cycle = 0;
  int         last_pop_cycle = 0;
  int         last_done_cycle = 0;
  int         last_ack_cycle = 0;
  int         start_cycle = 0;
  int         n_done = 0;
  int         n_ack = 0;
  int         n_err_pulse = 0;
  int         pop_while_empty = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic refresh();
    gate = toggle_en ? ~gate : 1'b0;
    bus.fifo_empty = (fifo_mem.size() == 0) || gate;
    bus.fifo_data  = (fifo_mem.size() != 0) ? fifo_mem[0] : 8'h00;
  endtask

  task automatic put(input logic [7:0] b, input bit is_resp);
    fifo_mem.push_back(b);
    if (is_resp) exp_q.push_back(b);
  endtask

  // One clock: sample the pop request before the edge, then update the FIFO
  // model and event counters just after the following falling edge.
  task automatic tick();
    #1;
    popped = bus.fifo_rd_en;
    if (popped && bus.fifo_empty) pop_while_empty++;
    @(posedge clk);
    @(negedge clk);
    cycle++;
    if (popped) begin
      last_pop_cycle = cycle;
      if (fifo_mem.size() != 0) void'(fifo_mem.pop_front());
    end
    if (done) begin n_done++; last_done_cycle = cycle; end
    if (ack_received) begin n_ack++; last_ack_cycle = cycle; end
    if (error) n_err_pulse++;
    refresh();
  endtask

  task automatic run_txn(input logic [7:0] el, input logic [AB:0] rl,
                         input logic [MAX-1:0] mk, input int budget);
    int k;
    refresh();
    k = 0;
    while (!ready && k < budget) begin tick(); k++; end
    check("ready_before_start", ready, 1'b1);
    echo_len = el; resp_len = rl; ack_mask = mk; start = 1'b1;
    n_done = 0; n_ack = 0; n_err_pulse = 0;
    tick();
    start = 1'b0;
    start_cycle = cycle;
    k = 0;
    while (!done && k < budget) begin tick(); k++; end
    check("done_within_budget", done, 1'b1);
  endtask

  task automatic check_capture(input string tag, input int n);
    logic [7:0] e;
    for (int i = 0; i < n; i++) begin
      if (exp_q.size() == 0) begin
        check($sformatf("%s_sb_underflow_%0d", tag, i), 32'd1, 32'd0);
      end else begin
        e = exp_q.pop_front();
        check($sformatf("%s_data_%0d", tag, i), resp_data[i], e);
      end
    end
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; echo_len = '0; resp_len = '0; ack_mask = '0;
    bus.fifo_data = 8'h00; bus.fifo_empty = 1'b1;
    @(negedge clk);
    // FIFO holds a byte during reset: it must not be popped.
    put(8'h99, 1'b0);
    refresh();
    tick(); tick();
    #1;
    check("rst_ready", ready, 1'b0);
    check("rst_done", done, 1'b0);
    check("rst_error", error, 1'b0);
    check("rst_ack", ack_received, 1'b0);
    check("rst_resp_count", resp_count, 0);
    check("rst_resp_data_zero", (resp_data == '0), 1'b1);
    check("rst_rd_en", bus.fifo_rd_en, 1'b0);
    rst = 1'b0;
    tick();
    check("ready_after_rst", ready, 1'b1);
    check("rst_no_pop", fifo_mem.size(), 1);
    fifo_mem.delete();
    refresh();

    // Echo discard followed by plain capture, 1 byte/cycle.
    put(8'h55, 0); put(8'h04, 0); put(8'hAA, 0); put(8'h12, 1); put(8'h34, 1);
    run_txn(8'd3, 5'd2, 16'h0000, 40);
    check("t1_error", error, 1'b0);
    check("t1_count", resp_count, 2);
    check("t1_latency", last_done_cycle - start_cycle, 5);
    check_capture("t1", 2);
    check("t1_drained", fifo_mem.size(), 0);
    check("t1_ready_low_at_done", ready, 1'b0);
    tick();
    check("t1_done_once", n_done, 1);
    check("t1_ready_back", ready, 1'b1);

    // Good ACK on the single response byte.
    put(8'h55, 0); put(8'h44, 0); put(8'h40, 1);
    run_txn(8'd2, 5'd1, 16'h0001, 40);
    check("t2_error", error, 1'b0);
    check("t2_ack_count", n_ack, 1);
    check("t2_ack_with_done", last_ack_cycle, last_done_cycle);
    check_capture("t2", 1);

    // Wrong ACK: stored, error with done, no ack pulse.
    put(8'h55, 0); put(8'h44, 0); put(8'h41, 1);
    run_txn(8'd2, 5'd1, 16'h0001, 40);
    check("t3_error", error, 1'b1);
    check("t3_ack_count", n_ack, 0);
    check("t3_count", resp_count, 1);
    check_capture("t3", 1);

    // Timeout: only the echo byte ever arrives.
    put(8'h55, 0);
    run_txn(8'd1, 5'd1, 16'h0000, 120);
    check("t4_error", error, 1'b1);
    check("t4_timeout_gap", last_done_cycle - last_pop_cycle, TO);
    check("t4_count", resp_count, 0);
    tick();
    check("t4_err_once", n_err_pulse, 1);
    check("t4_ready_back", ready, 1'b1);

    // Full buffer with the FIFO gated empty every other cycle.
    for (int i = 0; i < MAX; i++) put(8'($urandom_range(0, 255)), 1);
    toggle_en = 1;
    pop_while_empty = 0;
    run_txn(8'd0, 5'(MAX), 16'h0000, 80);
    toggle_en = 0;
    check("t5_error", error, 1'b0);
    check("t5_count", resp_count, MAX);
    check("t5_no_pop_empty", pop_while_empty, 0);
    check_capture("t5", MAX);

    // resp_len above capacity is clamped: one byte stays in the FIFO.
    for (int i = 0; i < MAX; i++) put(8'(8'hC0 + i), 1);
    put(8'hEE, 0);
    run_txn(8'd0, 5'd20, 16'h0000, 40);
    check("t6_count", resp_count, MAX);
    check("t6_left_in_fifo", fifo_mem.size(), 1);
    check_capture("t6", MAX);
    fifo_mem.delete();
    refresh();

    // Zero-length transaction; start during the done cycle is ignored.
    run_txn(8'd0, 5'd0, 16'h0000, 10);
    check("t7_immediate_done", last_done_cycle, start_cycle);
    check("t7_error", error, 1'b0);
    check("t7_ready_low", ready, 1'b0);
    start = 1'b1;
    tick();
    start = 1'b0;
    check("t7_start_ignored_done", done, 1'b0);
    check("t7_ready_back", ready, 1'b1);
    tick();
    check("t7_no_second_done", done, 1'b0);

    // Reset in the middle of CAPTURE, then a normal transaction.
    put(8'h11, 0); put(8'h22, 0); put(8'h33, 0);
    refresh();
    echo_len = 8'd0; resp_len = 5'd4; ack_mask = '0; start = 1'b1;
    n_done = 0; n_err_pulse = 0;
    tick();
    start = 1'b0;
    tick(); tick();
    check("t8_partial_count", resp_count, 2);
    rst = 1'b1;
    tick();
    #1;
    check("t8_rst_ready", ready, 1'b0);
    check("t8_rst_done", done, 1'b0);
    check("t8_rst_count", resp_count, 0);
    check("t8_rst_data_zero", (resp_data == '0), 1'b1);
    check("t8_rst_rd_en", bus.fifo_rd_en, 1'b0);
    tick();
    rst = 1'b0;
    check("t8_no_done", n_done + n_err_pulse, 0);
    fifo_mem.delete();
    exp_q.delete();
    refresh();
    tick();
    check("t8_ready_after_rst", ready, 1'b1);
    put(8'h55, 0); put(8'hAB, 1); put(8'h40, 1);
    run_txn(8'd1, 5'd2, 16'h0002, 40);
    check("t8_error", error, 1'b0);
    check("t8_ack_count", n_ack, 1);
    check("t8_count", resp_count, 2);
    check_capture("t8", 2);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule : tb_updi_response_collector
